// File: rtl/video_in_capture.sv
// Locks to DVI-style frame timing and re-emits active pixels as a valid/ready stream with sof/eol flags.
// Latency: bus cycle -> S1 -> FIFO write -> dout_valid (2 edges min); backpressure fills the FIFO, then drops and flags overflow.

module vic_fifo #(
   parameter int WIDTH = 26,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_vld,
   output logic             wr_rdy,
   input  logic [WIDTH-1:0] wr_dat,
   output logic             rd_vld,
   input  logic             rd_rdy,
   output logic [WIDTH-1:0] rd_dat
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             push, pop;

   // A pop frees the head slot on the same edge, so a full FIFO still accepts a push alongside it.
   assign rd_vld = (cnt_q != '0);
   assign wr_rdy = (cnt_q != FULL_CNT) || rd_rdy;
   assign rd_dat = mem_q[rd_ptr_q];
   assign push   = wr_vld && wr_rdy;
   assign pop    = rd_vld && rd_rdy;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_dat;
   end
endmodule

module video_in_capture #(
   parameter int H_ACTIVE_VIDEO = 800,
   parameter int V_ACTIVE_VIDEO = 600,
   parameter int FIFO_DEPTH     = 16
) (
   input  logic        pixel_clk,
   input  logic        rst,
   input  logic [23:0] video_in_pData,
   input  logic        video_in_pHSync,
   input  logic        video_in_pVSync,
   input  logic        video_in_pVDE,
   output logic [23:0] pixel_stream_dout,
   output logic        pixel_stream_dout_sof,
   output logic        pixel_stream_dout_eol,
   output logic        pixel_stream_dout_valid,
   input  logic        pixel_stream_dout_ready,
   output logic        locked,
   output logic        err_timing,
   output logic        err_overflow,
   input  logic        err_clear
);
   localparam int XW = $clog2(H_ACTIVE_VIDEO + 1);
   localparam int YW = $clog2(V_ACTIVE_VIDEO + 1);
   localparam logic [XW-1:0] X_MAX  = XW'(H_ACTIVE_VIDEO);
   localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE_VIDEO - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE_VIDEO - 1);

   localparam logic [1:0] ST_UNSYNC  = 2'd0;
   localparam logic [1:0] ST_WAIT_DE = 2'd1;
   localparam logic [1:0] ST_ACTIVE  = 2'd2;
   localparam logic [1:0] ST_BLANK   = 2'd3;

   typedef struct packed {
      logic        eol;
      logic        sof;
      logic [23:0] dat;
   } pix_t;

   logic [23:0]   s1_dat_q, s1_dat_d;
   logic          s1_hs_q, s1_hs_d;
   logic          s1_vs_q, s1_vs_d;
   logic          s1_de_q, s1_de_d;
   logic          s2_vs_q, s2_vs_d;
   logic          s2_de_q, s2_de_d;
   logic [1:0]    state_q, state_d;
   logic [XW-1:0] x_cnt_q, x_cnt_d;
   logic [YW-1:0] y_cnt_q, y_cnt_d;
   logic          locked_q, locked_d;
   logic          err_timing_q, err_timing_d;
   logic          err_overflow_q, err_overflow_d;

   logic vs_fall, vs_rise, de_fall;
   logic pix_wr, t_err, ovf;
   logic fifo_wr_rdy, fifo_rd_vld;
   pix_t wr_pix, rd_pix;

   assign vs_fall = s2_vs_q && !s1_vs_q;
   assign vs_rise = s1_vs_q && !s2_vs_q;
   assign de_fall = s2_de_q && !s1_de_q;

   assign wr_pix.eol = (x_cnt_q == X_LAST);
   assign wr_pix.sof = (x_cnt_q == '0) && (y_cnt_q == '0);
   assign wr_pix.dat = s1_dat_q;

   always_comb begin
      s1_dat_d = video_in_pData;
      s1_hs_d  = video_in_pHSync;
      s1_vs_d  = video_in_pVSync;
      s1_de_d  = video_in_pVDE;
      s2_vs_d  = s1_vs_q;
      s2_de_d  = s1_de_q;
      state_d  = state_q;
      x_cnt_d  = x_cnt_q;
      y_cnt_d  = y_cnt_q;
      locked_d = locked_q;
      pix_wr   = 1'b0;
      t_err    = 1'b0;

      case (state_q)
         ST_UNSYNC: begin
            if (vs_fall) state_d = ST_WAIT_DE;
         end
         ST_WAIT_DE: begin
            if (s1_de_q) begin
               if (s1_hs_q) begin
                  t_err = 1'b1;
               end else begin
                  pix_wr  = 1'b1;
                  x_cnt_d = x_cnt_q + 1'b1;
                  state_d = ST_ACTIVE;
               end
            end
         end
         ST_ACTIVE: begin
            if (vs_rise) begin
               t_err = 1'b1;
            end else if (s1_de_q) begin
               if (s1_hs_q || (x_cnt_q == X_MAX)) begin
                  t_err = 1'b1;
               end else begin
                  pix_wr  = 1'b1;
                  x_cnt_d = x_cnt_q + 1'b1;
               end
            end else if (de_fall) begin
               if (x_cnt_q != X_MAX) begin
                  t_err = 1'b1;
               end else begin
                  x_cnt_d = '0;
                  if (y_cnt_q == Y_LAST) begin
                     y_cnt_d  = '0;
                     state_d  = ST_BLANK;
                     locked_d = 1'b1;
                  end else begin
                     y_cnt_d = y_cnt_q + 1'b1;
                  end
               end
            end
         end
         default: begin
            if (s1_de_q)      t_err   = 1'b1;
            else if (vs_fall) state_d = ST_WAIT_DE;
         end
      endcase

      // Any violation drops the frame entirely; capture resumes only on a fresh VSync falling edge.
      ovf = pix_wr && !fifo_wr_rdy;
      if (t_err || ovf) begin
         state_d  = ST_UNSYNC;
         x_cnt_d  = '0;
         y_cnt_d  = '0;
         locked_d = 1'b0;
      end

      err_timing_d   = t_err ? 1'b1 : (err_clear ? 1'b0 : err_timing_q);
      err_overflow_d = ovf   ? 1'b1 : (err_clear ? 1'b0 : err_overflow_q);
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         s1_dat_q       <= '0;
         s1_hs_q        <= 1'b0;
         s1_vs_q        <= 1'b0;
         s1_de_q        <= 1'b0;
         s2_vs_q        <= 1'b0;
         s2_de_q        <= 1'b0;
         state_q        <= ST_UNSYNC;
         x_cnt_q        <= '0;
         y_cnt_q        <= '0;
         locked_q       <= 1'b0;
         err_timing_q   <= 1'b0;
         err_overflow_q <= 1'b0;
      end else begin
         s1_dat_q       <= s1_dat_d;
         s1_hs_q        <= s1_hs_d;
         s1_vs_q        <= s1_vs_d;
         s1_de_q        <= s1_de_d;
         s2_vs_q        <= s2_vs_d;
         s2_de_q        <= s2_de_d;
         state_q        <= state_d;
         x_cnt_q        <= x_cnt_d;
         y_cnt_q        <= y_cnt_d;
         locked_q       <= locked_d;
         err_timing_q   <= err_timing_d;
         err_overflow_q <= err_overflow_d;
      end
   end

   vic_fifo #(
      .WIDTH ($bits(pix_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (pixel_clk),
      .rst    (rst),
      .wr_vld (pix_wr),
      .wr_rdy (fifo_wr_rdy),
      .wr_dat (wr_pix),
      .rd_vld (fifo_rd_vld),
      .rd_rdy (pixel_stream_dout_ready),
      .rd_dat (rd_pix)
   );

   assign pixel_stream_dout_valid = fifo_rd_vld;
   assign pixel_stream_dout       = fifo_rd_vld ? rd_pix.dat : 24'd0;
   assign pixel_stream_dout_sof   = fifo_rd_vld && rd_pix.sof;
   assign pixel_stream_dout_eol   = fifo_rd_vld && rd_pix.eol;
   assign locked                  = locked_q;
   assign err_timing              = err_timing_q;
   assign err_overflow            = err_overflow_q;
endmodule

// File: doc/video_in_capture.md
Name: video_in_capture

Overview:
Receive-side counterpart of the display controller. It samples a DVI-style parallel video bus (pData/HSync/VSync/VDE) on the pixel clock and locks to frame timing. It re-emits active pixels as a valid/ready pixel stream through an internal FIFO, with start-of-frame and end-of-line sideband flags. It sits between a video input PHY or loopback and downstream pixel processing or frame-buffer writers, and flags timing violations and overflow.

Parameters:
H_ACTIVE_VIDEO, 800, active pixels per line
V_ACTIVE_VIDEO, 600, active lines per frame
FIFO_DEPTH, 16, output FIFO entries (power of 2, >=4)

Ports:
pixel_clk  input  1  pixel clock; all logic on posedge
rst  input  1  synchronous, active-high reset
video_in_pData  input  24  pixel data, valid when pVDE=1
video_in_pHSync  input  1  horizontal sync, active-high
video_in_pVSync  input  1  vertical sync, active-high
video_in_pVDE  input  1  active video enable
pixel_stream_dout  output  24  pixel data out
pixel_stream_dout_sof  output  1  first pixel of frame (x=0, y=0)
pixel_stream_dout_eol  output  1  last pixel of line (x=H_ACTIVE_VIDEO-1)
pixel_stream_dout_valid  output  1  output beat valid
pixel_stream_dout_ready  input  1  downstream accepts beat
locked  output  1  one full error-free frame captured since last resync
err_timing  output  1  sticky: line/frame length violation
err_overflow  output  1  sticky: pixel arrived with FIFO full
err_clear  input  1  one-cycle pulse clears both sticky errors

Behaviour:
- Input stage: all four video inputs are registered once (stage S1); edge detection uses S1 and its delayed copy.
- FSM states: UNSYNC, WAIT_DE, ACTIVE, BLANK. Reset -> UNSYNC.
  - UNSYNC: ignore pixels. On VSync falling edge (S1 1->0), go to WAIT_DE.
  - WAIT_DE: on first S1 VDE=1, go to ACTIVE; that pixel is x=0, y=0 and is written with sof=1.
  - ACTIVE: each VDE=1 cycle writes one pixel and increments x_cnt.
    - On VDE falling edge: x_cnt must equal H_ACTIVE_VIDEO. Then x_cnt=0 and y_cnt++. If y_cnt reaches V_ACTIVE_VIDEO, y_cnt=0, go to BLANK, set locked=1.
  - BLANK: wait for VSync falling edge, then go to WAIT_DE.
- Timing errors set err_timing, clear locked, zero the counters, and force UNSYNC. Pixels already written stay in the FIFO; nothing is recalled. Error conditions:
  - VDE=1 with x_cnt==H_ACTIVE_VIDEO (long line).
  - VDE falling with x_cnt!=H_ACTIVE_VIDEO (short line).
  - VDE=1 in BLANK (too many lines).
  - VSync rising while in ACTIVE (short frame).
- Sideband flags: eol=1 when x_cnt==H_ACTIVE_VIDEO-1; sof=1 only when x_cnt==0 and y_cnt==0. The pixel written is {eol, sof, data} (26 bits).
- FIFO:
  - Write occurs at the edge after the S1 capture. dout_valid rises no earlier than 2 pixel_clk edges after the bus cycle carrying the pixel.
  - Output pop occurs when valid&&ready.
  - dout, sof and eol hold stable while valid=1 and ready=0.
  - Simultaneous push and pop when full is legal and not an overflow (pop frees the slot the same edge).
- Overflow: a pixel to write while the FIFO is full and there is no pop that cycle. The pixel is dropped, err_overflow is set, locked is cleared, and the FSM goes to UNSYNC. A dropped frame is never partially re-aligned.
- err_clear clears the sticky errors the next edge. If a new error occurs in the same cycle, the error wins.
- HSync is sampled but only sanity-used: HSync=1 concurrent with VDE=1 is a timing error.
- Reset values: dout=0, sof=0, eol=0, valid=0, locked=0, err_timing=0, err_overflow=0; FIFO empty; counters 0. Reset mid-frame discards FIFO contents and requires a fresh VSync falling edge.
- Counter widths: $clog2(H_ACTIVE_VIDEO+1) and $clog2(V_ACTIVE_VIDEO+1).

Test Plan:
1. H_ACTIVE=8, V_ACTIVE=4, drive 2 legal frames from a display_controller instance, ready=1. Expect:
   - 64 beats total, sof on beats 0 and 32 only.
   - eol on every 8th beat.
   - Data matches the source sequence; locked=1 after the first frame's 4th line; no errors.
2. Reset deasserted mid-frame. Expect no output until the next VSync falling edge, then exactly 32 beats per frame starting with sof.
3. Inject a 7-pixel line in line 2. Expect:
   - err_timing=1 the edge after S1 VDE falls; locked=0.
   - The following frame after VSync is captured cleanly.
   - err_clear pulse returns err_timing to 0.
4. ready=0 for a full line with FIFO_DEPTH=4. Expect err_overflow=1 on the 5th pixel, locked=0, and only 4 beats delivered when ready returns.
5. Random ready (50%) over 3 legal frames with FIFO_DEPTH=16. Expect no overflow, all 96 beats in order, and dout stable while stalled.
6. Extra active line (5 lines) in one frame. Expect err_timing set on the first VDE in BLANK; recovery on the next frame.
